exec_alu: RTL and testbench
===========================

Name: exec_alu

Overview:
- Execution unit directly downstream of the reservation station.
- Accepts one dispatched op per cycle and computes RV32I integer, branch and jump results, plus RV32M multiply/divide.
- Broadcasts each result on the ALU result bus, which is consumed by the ROB, the RS and the LSB.
- Single-cycle ops have a 1-cycle latency; MUL and DIV/REM go through a multi-cycle FSM that raises busy back to the RS.

Parameters:
ROB_ID_W, 4, width of ROB tag
DIV_STEPS, 32, radix-2 divide iterations (fixed to data width)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
rdy  in  1  global enable; no state changes when low
rollback  in  1  pipeline flush, synchronous
exe_valid  in  1  dispatch strobe from RS
exe_opcode  in  7  instruction opcode
exe_func3  in  3  funct3
exe_func1  in  1  instr bit 30 (SUB/SRA select)
exe_mext  in  1  funct7==0000001 on OP opcode (RV32M)
exe_data1  in  32  rs1 value
exe_data2  in  32  rs2 value
exe_imm  in  32  sign-extended immediate
exe_off  in  32  branch/jump offset
exe_pc  in  32  instruction PC
exe_rob_target  in  ROB_ID_W  destination ROB tag
exe_is_c_extend  in  1  compressed instruction (length 2)
alu_busy  out  1  combinational; RS must not dispatch while high
alu_valid  out  1  result strobe, one cycle per op
alu_rob_id  out  ROB_ID_W  result tag
alu_data  out  32  rd value
alu_jump  out  1  branch taken / JALR
alu_pc  out  32  resolved next PC

Behaviour:
- Reset and rollback:
  - rst or rollback: state<=IDLE, pending slot cleared, alu_valid<=0, alu_jump<=0.
  - alu_rob_id, alu_data and alu_pc are reset to 0 on rst only.
  - rollback overrides exe_valid on the same edge; the op presented in that cycle is discarded.
- rdy low: all registers hold, including alu_valid.
- alu_valid: default 0 every edge; pulses for exactly one cycle per completed op.
- Pending slot (one entry):
  - Exists because RS dispatch is registered: RS may dispatch on the same edge that a multi-cycle op is accepted.
  - alu_busy = (state!=IDLE) || pend_full.
  - exe_valid while state!=IDLE: op is captured into the pending slot.
  - exe_valid while pend_full: protocol violation; the op is dropped. This is a bench assertion.
- Op source in IDLE: if pend_full, the pending op is taken; otherwise the exe_valid op is taken.
- FSM states:
  - IDLE:
    - Single-cycle op: alu_valid=1 with its result after the accepting edge (latency 1).
    - MUL/MULH/MULHSU/MULHU: latch operands, go to MUL.
    - DIV/DIVU/REM/REMU: latch operands as absolute values plus sign flags, counter=31, go to DIV_ITER.
  - MUL: 33x33 signed product computed and registered; output selected (low or high word); alu_valid=1; go to IDLE. Latency 2.
  - DIV_ITER: one restoring shift-subtract step per cycle; on counter==0 go to DIV_FIX.
  - DIV_FIX: apply signs; alu_valid=1; go to IDLE. Latency 34 edges from acceptance.
- Single-cycle result rules:
  - LUI: data=imm.
  - AUIPC: pc+imm.
  - OP/OP-IMM: operand2 = data2 or imm. Shift amount = operand2[4:0]. func1 selects SUB (OP only) and SRA/SRAI.
  - JAL: data=pc+len, jump=0, pc=pc+off.
  - JALR: data=pc+len, jump=1, pc=(data1+imm)&~1.
  - Branch (BEQ/BNE/BLT/BGE/BLTU/BGEU): data=0, jump=taken, pc=taken ? pc+off : pc+len.
  - len = 2 if exe_is_c_extend, else 4.
  - Non-branch ops: jump=0, pc=pc+len.
- RV32M boundary values:
  - Divide by zero: quotient=0xFFFFFFFF, remainder=dividend.
  - Signed overflow (0x80000000 / -1): quotient=0x80000000, remainder=0.
  - Without the early-out feature both still take the full 34 cycles.
  - All arithmetic is modulo 2^32.
- Unknown opcode: alu_valid=1 with data=0, jump=0, pc=pc+len; the ROB is never left waiting.

Optional Feature:
DIV_EARLY_OUT_EN
- Defined: in IDLE, divide by zero, signed overflow, and |dividend|<|divisor| complete directly with latency 1; FSM stays IDLE and alu_busy stays low.
- Undefined: every DIV/REM takes the full 34-cycle path.

Test Plan:
- Reset: rst high 2 cycles with exe_valid=1 -> alu_valid=0, alu_busy=0, alu_data=0 throughout.
- ADD: data1=5, data2=0xFFFFFFFD, rob 3 -> next cycle alu_valid=1, rob_id=3, data=2. Then SRAI with data1=0x80000000, imm=4, func1=1 -> data=0xF8000000.
- Branch: BLT with data1=-1, data2=1, pc=0x100, off=0x20, c_extend=1 -> jump=1, pc=0x120. BGEU with the same operands -> jump=1, pc=0x120. BEQ with unequal operands -> jump=0, pc=0x102.
- DIV: -7 / 2 with rob 5, second ADD dispatched on the next edge ->
  - alu_busy high from cycle 1.
  - ADD held in the pending slot.
  - DIV result 0xFFFFFFFD appears 34 cycles after acceptance.
  - ADD result follows one cycle later.
  - REM -7 % 2 = 0xFFFFFFFF.
- Boundaries: DIVU by 0 -> 0xFFFFFFFF. REM 0x80000000 % -1 -> 0. MULH 0x80000000*0x80000000 -> 0x40000000, latency 2. Repeat with DIV_EARLY_OUT_EN defined -> divide-by-zero latency 1.
- Rollback at cycle 10 of a DIV with the pending slot full -> no alu_valid afterwards, alu_busy=0 next cycle, and a new ADD is accepted immediately.

Source files
------------

// File: rtl/exec_alu.sv
// exec_alu: RV32I/RV32M execution unit feeding the ALU result bus; MUL/DIV run on a small FSM.
// Define DIV_EARLY_OUT_EN to finish trivial divides (by zero, overflow, |a|<|b|) in one cycle.
module exec_alu #(
    parameter int unsigned ROB_ID_W  = 4,
    parameter int unsigned DIV_STEPS = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic                rollback,
    input  logic                exe_valid,
    input  logic [6:0]          exe_opcode,
    input  logic [2:0]          exe_func3,
    input  logic                exe_func1,
    input  logic                exe_mext,
    input  logic [31:0]         exe_data1,
    input  logic [31:0]         exe_data2,
    input  logic [31:0]         exe_imm,
    input  logic [31:0]         exe_off,
    input  logic [31:0]         exe_pc,
    input  logic [ROB_ID_W-1:0] exe_rob_target,
    input  logic                exe_is_c_extend,
    output logic                alu_busy,
    output logic                alu_valid,
    output logic [ROB_ID_W-1:0] alu_rob_id,
    output logic [31:0]         alu_data,
    output logic                alu_jump,
    output logic [31:0]         alu_pc
);
    localparam int unsigned CNT_W = $clog2(DIV_STEPS);
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [1:0] {IDLE, MUL, DIV_ITER, DIV_FIX} state_t;

    typedef struct packed {
        logic [6:0]          opcode;
        logic [2:0]          func3;
        logic                func1;
        logic                mext;
        logic [31:0]         data1;
        logic [31:0]         data2;
        logic [31:0]         imm;
        logic [31:0]         off;
        logic [31:0]         pc;
        logic [ROB_ID_W-1:0] rob;
        logic                c_ext;
    } op_t;

    state_t              state, state_nx;
    op_t                 exe_op, cur, pend, pend_nx;
    logic                pend_full, pend_full_nx, take;
    logic [CNT_W-1:0]    cnt, cnt_nx;
    logic [32:0]         opa, opa_nx, opb, opb_nx;
    logic [31:0]         rem, rem_nx;
    logic                neg_q, neg_q_nx, neg_r, neg_r_nx, sel_hi, sel_hi_nx;
    logic [ROB_ID_W-1:0] m_rob, m_rob_nx, rob_nx;
    logic [31:0]         m_pc, m_pc_nx, data_nx, pc_nx;
    logic                valid_nx, jump_nx;

    logic [31:0] len, pc_seq, op2, sc_data, sc_pc;
    logic [4:0]  shamt;
    logic        sc_jump, br_take, is_mul, is_div, div_sgn;
    logic [31:0] abs_a, abs_b, quo_fix, rem_fix, eo_q, eo_r;
    logic [32:0] mul_a, mul_b, div_sh;
    logic        div_ge, eo_hit;
    logic [31:0] div_rem;
    logic [63:0] mul_prod;

    assign alu_busy = (state != IDLE) || pend_full;

    always_comb begin : op_select
        exe_op.opcode = exe_opcode;
        exe_op.func3  = exe_func3;
        exe_op.func1  = exe_func1;
        exe_op.mext   = exe_mext;
        exe_op.data1  = exe_data1;
        exe_op.data2  = exe_data2;
        exe_op.imm    = exe_imm;
        exe_op.off    = exe_off;
        exe_op.pc     = exe_pc;
        exe_op.rob    = exe_rob_target;
        exe_op.c_ext  = exe_is_c_extend;
        cur  = pend_full ? pend : exe_op;
        take = pend_full || exe_valid;
    end

    // Single-cycle integer, branch and jump results for the op selected in IDLE.
    always_comb begin : single_cycle
        len     = cur.c_ext ? 32'd2 : 32'd4;
        pc_seq  = cur.pc + len;
        op2     = (cur.opcode == OPC_OP) ? cur.data2 : cur.imm;
        shamt   = op2[4:0];
        sc_data = '0;
        sc_jump = 1'b0;
        sc_pc   = pc_seq;
        br_take = 1'b0;
        case (cur.opcode)
            OPC_LUI:   sc_data = cur.imm;
            OPC_AUIPC: sc_data = cur.pc + cur.imm;
            OPC_OP, OPC_OP_IMM: begin
                case (cur.func3)
                    3'b000: sc_data = (cur.opcode == OPC_OP && cur.func1) ? cur.data1 - op2
                                                                         : cur.data1 + op2;
                    3'b001: sc_data = cur.data1 << shamt;
                    3'b010: sc_data = {31'd0, $signed(cur.data1) < $signed(op2)};
                    3'b011: sc_data = {31'd0, cur.data1 < op2};
                    3'b100: sc_data = cur.data1 ^ op2;
                    3'b101: sc_data = cur.func1 ? 32'($signed(cur.data1) >>> shamt)
                                                : cur.data1 >> shamt;
                    3'b110: sc_data = cur.data1 | op2;
                    3'b111: sc_data = cur.data1 & op2;
                endcase
            end
            OPC_JAL: begin
                sc_data = pc_seq;
                sc_pc   = cur.pc + cur.off;
            end
            OPC_JALR: begin
                sc_data = pc_seq;
                sc_jump = 1'b1;
                sc_pc   = (cur.data1 + cur.imm) & ~32'd1;
            end
            OPC_BRANCH: begin
                case (cur.func3)
                    3'b000:  br_take = cur.data1 == cur.data2;
                    3'b001:  br_take = cur.data1 != cur.data2;
                    3'b100:  br_take = $signed(cur.data1) <  $signed(cur.data2);
                    3'b101:  br_take = $signed(cur.data1) >= $signed(cur.data2);
                    3'b110:  br_take = cur.data1 <  cur.data2;
                    3'b111:  br_take = cur.data1 >= cur.data2;
                    default: br_take = 1'b0;
                endcase
                sc_jump = br_take;
                sc_pc   = br_take ? cur.pc + cur.off : pc_seq;
            end
            default: ;
        endcase
    end

    // Multiply/divide operand prep, divider step, and final sign fix-up.
    always_comb begin : muldiv_path
        is_mul  = (cur.opcode == OPC_OP) && cur.mext && !cur.func3[2];
        is_div  = (cur.opcode == OPC_OP) && cur.mext &&  cur.func3[2];
        mul_a   = {(cur.func3[1:0] != 2'b11) & cur.data1[31], cur.data1};
        mul_b   = {~cur.func3[1] & cur.data2[31], cur.data2};
        div_sgn = ~cur.func3[0];
        abs_a   = (div_sgn && cur.data1[31]) ? -cur.data1 : cur.data1;
        abs_b   = (div_sgn && cur.data2[31]) ? -cur.data2 : cur.data2;
        div_sh  = {rem, opa[31]};
        div_ge  = div_sh >= {1'b0, opb[31:0]};
        div_rem = div_ge ? 32'(div_sh - {1'b0, opb[31:0]}) : div_sh[31:0];
        mul_prod = {{31{opa[32]}}, opa} * {{31{opb[32]}}, opb};
        quo_fix = neg_q ? -opa[31:0] : opa[31:0];
        rem_fix = neg_r ? -rem : rem;
`ifdef DIV_EARLY_OUT_EN
        eo_hit = 1'b0;
        eo_q   = '0;
        eo_r   = cur.data1;
        if (cur.data2 == '0) begin
            eo_hit = 1'b1;
            eo_q   = '1;
        end else if (div_sgn && cur.data1 == 32'h8000_0000 && cur.data2 == '1) begin
            eo_hit = 1'b1;
            eo_q   = 32'h8000_0000;
            eo_r   = '0;
        end else if (abs_a < abs_b) begin
            eo_hit = 1'b1;
        end
`else
        eo_hit = 1'b0;
        eo_q   = '0;
        eo_r   = '0;
`endif
    end

    always_comb begin : fsm_next
        state_nx     = state;
        pend_full_nx = pend_full;
        pend_nx      = pend;
        cnt_nx       = cnt;
        opa_nx       = opa;
        opb_nx       = opb;
        rem_nx       = rem;
        neg_q_nx     = neg_q;
        neg_r_nx     = neg_r;
        sel_hi_nx    = sel_hi;
        m_rob_nx     = m_rob;
        m_pc_nx      = m_pc;
        valid_nx     = 1'b0;
        rob_nx       = alu_rob_id;
        data_nx      = alu_data;
        jump_nx      = alu_jump;
        pc_nx        = alu_pc;
        if (rollback) begin
            state_nx     = IDLE;
            pend_full_nx = 1'b0;
            jump_nx      = 1'b0;
        end else begin
            if (exe_valid && state != IDLE && !pend_full) begin
                pend_full_nx = 1'b1;
                pend_nx      = exe_op;
            end
            case (state)
                IDLE: if (take) begin
                    pend_full_nx = 1'b0;
                    m_rob_nx     = cur.rob;
                    m_pc_nx      = pc_seq;
                    if (is_mul) begin
                        opa_nx    = mul_a;
                        opb_nx    = mul_b;
                        sel_hi_nx = cur.func3[1:0] != 2'b00;
                        state_nx  = MUL;
                    end else if (is_div && !eo_hit) begin
                        opa_nx    = {1'b0, abs_a};
                        opb_nx    = {1'b0, abs_b};
                        rem_nx    = '0;
                        neg_q_nx  = div_sgn && (cur.data1[31] ^ cur.data2[31]) && (cur.data2 != '0);
                        neg_r_nx  = div_sgn && cur.data1[31];
                        sel_hi_nx = cur.func3[1];
                        cnt_nx    = CNT_W'(DIV_STEPS - 1);
                        state_nx  = DIV_ITER;
                    end else begin
                        valid_nx = 1'b1;
                        rob_nx   = cur.rob;
                        data_nx  = is_div ? (cur.func3[1] ? eo_r : eo_q) : sc_data;
                        jump_nx  = sc_jump;
                        pc_nx    = sc_pc;
                    end
                end
                MUL: begin
                    valid_nx = 1'b1;
                    rob_nx   = m_rob;
                    data_nx  = sel_hi ? mul_prod[63:32] : mul_prod[31:0];
                    jump_nx  = 1'b0;
                    pc_nx    = m_pc;
                    state_nx = IDLE;
                end
                DIV_ITER: begin
                    opa_nx = {1'b0, opa[30:0], div_ge};
                    rem_nx = div_rem;
                    if (cnt == '0) state_nx = DIV_FIX;
                    else           cnt_nx   = cnt - CNT_W'(1);
                end
                DIV_FIX: begin
                    valid_nx = 1'b1;
                    rob_nx   = m_rob;
                    data_nx  = sel_hi ? rem_fix : quo_fix;
                    jump_nx  = 1'b0;
                    pc_nx    = m_pc;
                    state_nx = IDLE;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            pend_full  <= 1'b0;
            pend       <= '0;
            cnt        <= '0;
            opa        <= '0;
            opb        <= '0;
            rem        <= '0;
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
            sel_hi     <= 1'b0;
            m_rob      <= '0;
            m_pc       <= '0;
            alu_valid  <= 1'b0;
            alu_rob_id <= '0;
            alu_data   <= '0;
            alu_jump   <= 1'b0;
            alu_pc     <= '0;
        end else if (rdy) begin
            state      <= state_nx;
            pend_full  <= pend_full_nx;
            pend       <= pend_nx;
            cnt        <= cnt_nx;
            opa        <= opa_nx;
            opb        <= opb_nx;
            rem        <= rem_nx;
            neg_q      <= neg_q_nx;
            neg_r      <= neg_r_nx;
            sel_hi     <= sel_hi_nx;
            m_rob      <= m_rob_nx;
            m_pc       <= m_pc_nx;
            alu_valid  <= valid_nx;
            alu_rob_id <= rob_nx;
            alu_data   <= data_nx;
            alu_jump   <= jump_nx;
            alu_pc     <= pc_nx;
        end
    end
endmodule

// File: tb/tb_exec_alu.sv
// Scoreboard bench for exec_alu: directed ops push expected results; a negedge monitor checks them.
module tb_exec_alu;
    localparam int unsigned ROB_ID_W = 4;
    localparam logic [6:0] OP    = 7'b0110011;
    localparam logic [6:0] OPI   = 7'b0010011;
    localparam logic [6:0] BR    = 7'b1100011;
    localparam logic [6:0] JALR  = 7'b1100111;
    localparam logic [6:0] JAL   = 7'b1101111;
    localparam logic [6:0] LUI   = 7'b0110111;
    localparam logic [6:0] AUIPC = 7'b0010111;
`ifdef DIV_EARLY_OUT_EN
    localparam int EO_LAT = 1;
`else
    localparam int EO_LAT = 34;
`endif

    logic                clk, rst, rdy, rollback, exe_valid;
    logic [6:0]          exe_opcode;
    logic [2:0]          exe_func3;
    logic                exe_func1, exe_mext, exe_is_c_extend;
    logic [31:0]         exe_data1, exe_data2, exe_imm, exe_off, exe_pc;
    logic [ROB_ID_W-1:0] exe_rob_target;
    logic                alu_busy, alu_valid, alu_jump;
    logic [ROB_ID_W-1:0] alu_rob_id;
    logic [31:0]         alu_data, alu_pc;

    exec_alu #(.ROB_ID_W(ROB_ID_W)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
        .exe_valid(exe_valid), .exe_opcode(exe_opcode), .exe_func3(exe_func3),
        .exe_func1(exe_func1), .exe_mext(exe_mext), .exe_data1(exe_data1),
        .exe_data2(exe_data2), .exe_imm(exe_imm), .exe_off(exe_off), .exe_pc(exe_pc),
        .exe_rob_target(exe_rob_target), .exe_is_c_extend(exe_is_c_extend),
        .alu_busy(alu_busy), .alu_valid(alu_valid), .alu_rob_id(alu_rob_id),
        .alu_data(alu_data), .alu_jump(alu_jump), .alu_pc(alu_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [ROB_ID_W-1:0] rob;
        logic [31:0]         data;
        logic                jump;
        logic [31:0]         pc;
        int                  cyc;
    } exp_t;

    exp_t sb[$];
    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Monitor: every result strobe must match the oldest expected entry, on the expected cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (alu_valid === 1'b1) begin
                n_checks++;
                if (sb.size() == 0) begin
                    $display("FAIL unexpected_result: got rob %0d data %h pc %h at cyc %0d, expected no result",
                             alu_rob_id, alu_data, alu_pc, cyc);
                end else begin
                    e = sb.pop_front();
                    if (alu_rob_id === e.rob && alu_data === e.data && alu_jump === e.jump &&
                        alu_pc === e.pc && cyc == e.cyc)
                        n_pass++;
                    else
                        $display("FAIL result_rob%0d: got rob %0d data %h jump %0b pc %h cyc %0d, expected rob %0d data %h jump %0b pc %h cyc %0d",
                                 e.rob, alu_rob_id, alu_data, alu_jump, alu_pc, cyc,
                                 e.rob, e.data, e.jump, e.pc, e.cyc);
                end
            end
        end
    end

    always @(posedge clk)
        if (!rst && rdy && !rollback && exe_valid)
            assert (!dut.pend_full) else $error("FAIL pend_overflow: dispatch while pending slot full");

    task automatic set_op(input logic [6:0] opc, input int f3, input int f1, input int mx,
                          input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                          input logic [31:0] off, input logic [31:0] pc, input int rob, input int c);
        exe_opcode      = opc;
        exe_func3       = 3'(f3);
        exe_func1       = 1'(f1);
        exe_mext        = 1'(mx);
        exe_data1       = d1;
        exe_data2       = d2;
        exe_imm         = imm;
        exe_off         = off;
        exe_pc          = pc;
        exe_rob_target  = ROB_ID_W'(rob);
        exe_is_c_extend = 1'(c);
    endtask

    // Dispatch one op for one edge; lat>0 pushes the expected result due lat cycles later.
    task automatic issue(input logic [6:0] opc, input int f3, input int f1, input int mx,
                         input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                         input logic [31:0] off, input logic [31:0] pc, input int rob, input int c,
                         input int lat, input logic [31:0] ed, input int ej, input logic [31:0] ep);
        set_op(opc, f3, f1, mx, d1, d2, imm, off, pc, rob, c);
        exe_valid = 1'b1;
        if (lat > 0)
            sb.push_back('{rob: ROB_ID_W'(rob), data: ed, jump: 1'(ej), pc: ep, cyc: cyc + lat});
        @(posedge clk);
        #1;
        exe_valid = 1'b0;
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while ((sb.size() != 0 || alu_busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, {31'd0, (sb.size() != 0 || alu_busy)}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; rdy = 1'b1; rollback = 1'b0;
        set_op(OP, 0, 0, 0, 1, 1, 0, 0, 'h10, 1, 0);
        exe_valid = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("reset_valid", 32'(alu_valid), 32'd0);
            chk("reset_busy",  32'(alu_busy),  32'd0);
            chk("reset_data",  alu_data,       32'd0);
        end
        rst = 1'b0;
        exe_valid = 1'b0;
        @(negedge clk);

        // Single-cycle ops back to back
        issue(OP,    0, 0, 0, 5, 'hFFFFFFFD, 0, 0, 'h40, 3, 0, 1, 2, 0, 'h44);
        issue(OPI,   5, 1, 0, 'h80000000, 0, 4, 0, 'h44, 4, 0, 1, 'hF8000000, 0, 'h48);
        issue(OP,    0, 1, 0, 5, 7, 0, 0, 'h48, 1, 0, 1, 'hFFFFFFFE, 0, 'h4C);
        issue(BR,    4, 0, 0, 'hFFFFFFFF, 1, 0, 'h20, 'h100, 6, 1, 1, 0, 1, 'h120);
        issue(BR,    7, 0, 0, 'hFFFFFFFF, 1, 0, 'h20, 'h100, 7, 1, 1, 0, 1, 'h120);
        issue(BR,    0, 0, 0, 'hFFFFFFFF, 1, 0, 'h20, 'h100, 8, 1, 1, 0, 0, 'h102);
        issue(JALR,  0, 0, 0, 'h1001, 0, 'h10, 0, 'h200, 9, 0, 1, 'h204, 1, 'h1010);
        issue(JAL,   0, 0, 0, 0, 0, 0, 'h40, 'h200, 10, 1, 1, 'h202, 0, 'h240);
        issue(LUI,   0, 0, 0, 0, 0, 'h12345000, 0, 'h210, 11, 0, 1, 'h12345000, 0, 'h214);
        issue(AUIPC, 0, 0, 0, 0, 0, 'h1000, 0, 'h210, 12, 0, 1, 'h1210, 0, 'h214);
        issue(7'h00, 0, 0, 0, 9, 9, 9, 9, 'h300, 13, 0, 1, 0, 0, 'h304);
        issue(OP,    3, 0, 0, 'hFFFFFFFF, 1, 0, 0, 'h304, 14, 0, 1, 0, 0, 'h308);
        drain("drain_single", 10);

        // DIV with an ADD landing in the pending slot
        issue(OP, 4, 0, 1, 'hFFFFFFF9, 2, 0, 0, 'h400, 5, 0, 34, 'hFFFFFFFD, 0, 'h404);
        chk("busy_div", 32'(alu_busy), 32'd1);
        issue(OP, 0, 0, 0, 1, 2, 0, 0, 'h404, 7, 0, 34, 3, 0, 'h408);
        chk("busy_pend", 32'(alu_busy), 32'd1);
        drain("drain_div", 60);

        issue(OP, 6, 0, 1, 'hFFFFFFF9, 2, 0, 0, 'h408, 2, 0, 34, 'hFFFFFFFF, 0, 'h40C);
        drain("drain_rem", 60);
        issue(OP, 5, 0, 1, 'h1234, 0, 0, 0, 'h40C, 3, 0, EO_LAT, 'hFFFFFFFF, 0, 'h410);
        drain("drain_divu0", 60);
        issue(OP, 4, 0, 1, 'hFFFFFFF9, 0, 0, 0, 'h410, 4, 1, EO_LAT, 'hFFFFFFFF, 0, 'h412);
        drain("drain_div0", 60);
        issue(OP, 6, 0, 1, 'h80000000, 'hFFFFFFFF, 0, 0, 'h412, 5, 0, EO_LAT, 0, 0, 'h416);
        drain("drain_rem_ovf", 60);
        issue(OP, 4, 0, 1, 'h80000000, 'hFFFFFFFF, 0, 0, 'h416, 6, 0, EO_LAT, 'h80000000, 0, 'h41A);
        drain("drain_div_ovf", 60);
        issue(OP, 7, 0, 1, 3, 5, 0, 0, 'h41A, 7, 0, EO_LAT, 3, 0, 'h41E);
        drain("drain_remu_small", 60);
        issue(OP, 5, 0, 1, 100, 7, 0, 0, 'h41E, 8, 0, 34, 14, 0, 'h422);
        drain("drain_divu", 60);
        issue(OP, 4, 0, 1, 100, 'hFFFFFFF9, 0, 0, 'h422, 9, 0, 34, 'hFFFFFFF2, 0, 'h426);
        drain("drain_div_neg", 60);
        issue(OP, 6, 0, 1, 'hFFFFFF9C, 7, 0, 0, 'h426, 10, 0, 34, 'hFFFFFFFE, 0, 'h42A);
        drain("drain_rem_neg", 60);

        // Multiplies, latency 2; the first is followed by a pending ADD
        issue(OP, 1, 0, 1, 'h80000000, 'h80000000, 0, 0, 'h500, 11, 0, 2, 'h40000000, 0, 'h504);
        chk("busy_mul", 32'(alu_busy), 32'd1);
        issue(OP, 0, 0, 0, 10, 20, 0, 0, 'h504, 12, 0, 2, 30, 0, 'h508);
        drain("drain_mulh", 10);
        issue(OP, 0, 0, 1, 7, 'hFFFFFFFD, 0, 0, 'h508, 13, 0, 2, 'hFFFFFFEB, 0, 'h50C);
        drain("drain_mul", 10);
        issue(OP, 3, 0, 1, 'hFFFFFFFF, 'hFFFFFFFF, 0, 0, 'h50C, 14, 0, 2, 'hFFFFFFFE, 0, 'h510);
        drain("drain_mulhu", 10);
        issue(OP, 2, 0, 1, 'hFFFFFFFF, 'hFFFFFFFF, 0, 0, 'h510, 15, 0, 2, 'hFFFFFFFF, 0, 'h514);
        drain("drain_mulhsu", 10);

        // Rollback mid-divide with the pending slot full; the op on the rollback edge is dropped
        issue(OP, 5, 0, 1, 100, 7, 0, 0, 'h600, 9, 0, 0, 0, 0, 0);
        issue(OP, 0, 0, 0, 1, 1, 0, 0, 'h604, 10, 0, 0, 0, 0, 0);
        repeat (7) @(posedge clk);
        #1;
        set_op(OP, 0, 0, 0, 2, 2, 0, 0, 'h608, 12, 0);
        exe_valid = 1'b1;
        rollback  = 1'b1;
        @(posedge clk);
        #1;
        rollback  = 1'b0;
        exe_valid = 1'b0;
        chk("rollback_busy",  32'(alu_busy),  32'd0);
        chk("rollback_valid", 32'(alu_valid), 32'd0);
        issue(OP, 0, 0, 0, 20, 22, 0, 0, 'h700, 13, 0, 1, 42, 0, 'h704);
        drain("drain_after_rollback", 10);
        repeat (40) @(negedge clk);
        chk("final_idle", {31'd0, alu_busy}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
